sfp_port_array: RTL and testbench

Multi-cage SFP(+) sideband manager: a parametrised successor to the single-cage SFP port block. It serves `PORTS` cages from one Avalon-MM register window and adds, per cage, input synchronisation, debouncing, sticky W1C event registers, a maskable interrupt, a stretched I2C-core reset pulse and automatic TX disable on removal or fault. It sits between the board SFP sideband pins and the management CPU. The per-cage I2C open-drain pins stay with the existing I2C bus drivers.

---
 rtl/sfp_port_array.sv | 156 +++++++++++++++
 tb/tb_sfp_port_array.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_port_array.sv
// Multi-cage SFP sideband manager: synchronised and debounced status inputs,
// sticky W1C events, maskable irq, stretched I2C reset and auto TX disable.
module sfp_port_array #(
  parameter int PORTS           = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int I2C_RST_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORTS-1:0]     los,
  input  logic [PORTS-1:0]     mod0_prsnt_n,
  input  logic [PORTS-1:0]     tx_fault,
  output logic [PORTS-1:0]     tx_disable,
  output logic [2*PORTS-1:0]   ratesel,
  output logic [PORTS-1:0]     i2c_reset,
  output logic                 irq,
  input  logic [5:0]           mm_address,
  input  logic                 mm_read,
  output logic [7:0]           mm_readdata,
  input  logic                 mm_write,
  input  logic [7:0]           mm_writedata,
  output logic [1:0]           mm_response
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(I2C_RST_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RST_LEN = RW'(I2C_RST_CYCLES);
  // Input vector order per cage: {fault, los, present}; debounced reset value.
  localparam logic [2:0] IN_RST = 3'b010;

  logic [2:0]    raw      [PORTS];
  logic [2:0]    meta     [PORTS];
  logic [2:0]    sync     [PORTS];
  logic [2:0]    deb      [PORTS];
  logic [2:0]    deb_nxt  [PORTS];
  logic [DW-1:0] db_cnt   [PORTS][3];
  logic [DW-1:0] cnt_nxt  [PORTS][3];
  logic [4:0]    ev_set   [PORTS];
  logic [4:0]    event_q  [PORTS];
  logic [4:0]    mask_q   [PORTS];
  logic [1:0]    auto_q   [PORTS];
  logic [1:0]    rate_q   [PORTS];
  logic [RW-1:0] rst_cnt  [PORTS];
  logic [PORTS-1:0] tx_q;
  logic [PORTS-1:0] insert_q;
  logic [PORTS-1:0] wr_ctrl, wr_event, wr_mask, wr_auto, force_tx;

  logic [3:0] port;
  logic [1:0] reg_idx;
  logic       port_ok;
  logic [7:0] rd_mux;
  logic       unused_bits;

  assign port        = mm_address[5:2];
  assign reg_idx     = mm_address[1:0];
  assign port_ok     = (int'(port) < PORTS);
  assign unused_bits = mm_writedata[7];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      raw[p] = {tx_fault[p], los[p], ~mod0_prsnt_n[p]};
      for (int i = 0; i < 3; i++) begin
        deb_nxt[p][i] = deb[p][i];
        cnt_nxt[p][i] = '0;
        if (sync[p][i] != deb[p][i]) begin
          if (db_cnt[p][i] == DB_LAST) deb_nxt[p][i] = sync[p][i];
          else                         cnt_nxt[p][i] = db_cnt[p][i] + 1'b1;
        end
      end
      ev_set[p] = { deb_nxt[p][2] & ~deb[p][2],   // fault rise
                   ~deb_nxt[p][1] &  deb[p][1],   // los fall
                    deb_nxt[p][1] & ~deb[p][1],   // los rise
                   ~deb_nxt[p][0] &  deb[p][0],   // remove
                    deb_nxt[p][0] & ~deb[p][0]};  // insert
      wr_ctrl[p]  = mm_write && (port == 4'(p)) && (reg_idx == 2'd0);
      wr_event[p] = mm_write && (port == 4'(p)) && (reg_idx == 2'd1);
      wr_mask[p]  = mm_write && (port == 4'(p)) && (reg_idx == 2'd2);
      wr_auto[p]  = mm_write && (port == 4'(p)) && (reg_idx == 2'd3);
      force_tx[p] = (auto_q[p][0] & ev_set[p][1]) | (auto_q[p][1] & ev_set[p][4]);
    end
  end

  // Ports beyond PORTS match no cage, so their reads fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (port == 4'(p)) begin
        case (reg_idx)
          2'd0:    rd_mux = {1'b0, i2c_reset[p], rate_q[p], tx_q[p], deb[p]};
          2'd1:    rd_mux = {3'b000, event_q[p]};
          2'd2:    rd_mux = {3'b000, mask_q[p]};
          default: rd_mux = {6'b000000, auto_q[p]};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PORTS; p++) begin
        meta[p]    <= IN_RST;
        sync[p]    <= IN_RST;
        deb[p]     <= IN_RST;
        for (int i = 0; i < 3; i++) db_cnt[p][i] <= '0;
        event_q[p] <= '0;
        mask_q[p]  <= '0;
        auto_q[p]  <= 2'b11;
        rate_q[p]  <= '0;
        rst_cnt[p] <= '0;
      end
      tx_q        <= '1;
      insert_q    <= '0;
      mm_readdata <= '0;
      mm_response <= 2'b00;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        meta[p] <= raw[p];
        sync[p] <= meta[p];
        deb[p]  <= deb_nxt[p];
        for (int i = 0; i < 3; i++) db_cnt[p][i] <= cnt_nxt[p][i];
        insert_q[p] <= ev_set[p][0];
        // A new event outranks a simultaneous W1C of the same bit.
        event_q[p] <= (event_q[p] & ~(wr_event[p] ? mm_writedata[4:0] : 5'b0)) | ev_set[p];
        if (wr_mask[p]) mask_q[p] <= mm_writedata[4:0];
        if (wr_auto[p]) auto_q[p] <= mm_writedata[1:0];
        if (wr_ctrl[p]) begin
          tx_q[p]   <= mm_writedata[3];
          rate_q[p] <= mm_writedata[5:4];
        end
        if (force_tx[p]) tx_q[p] <= 1'b1;
        if (insert_q[p] || (wr_ctrl[p] && mm_writedata[6])) rst_cnt[p] <= RST_LEN;
        else if (rst_cnt[p] != '0)                          rst_cnt[p] <= rst_cnt[p] - 1'b1;
      end
      if (mm_read) begin
        mm_readdata <= rd_mux;
        mm_response <= port_ok ? 2'b00 : 2'b11;
      end else begin
        mm_response <= 2'b00;
      end
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_out
    assign ratesel[2*g +: 2] = rate_q[g];
    assign i2c_reset[g]      = reset | (rst_cnt[g] != '0);
  end

  assign tx_disable = tx_q;

  always_comb begin
    irq = 1'b0;
    for (int p = 0; p < PORTS; p++) irq = irq | (|(event_q[p] & mask_q[p]));
  end

endmodule

// File: tb/tb_sfp_port_array.sv
// Bench for sfp_port_array: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the cages and registers.
module tb_sfp_port_array;
  localparam int PORTS = 2;
  localparam int DB    = 8;
  localparam int RST   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] los, prsnt_n, fault;
  logic [1:0] tx_disable, i2c_reset;
  logic [3:0] ratesel;
  logic       irq;
  logic [5:0] mm_address;
  logic       mm_read, mm_write;
  logic [7:0] mm_readdata, mm_writedata;
  logic [1:0] mm_response;

  int n_cmp = 0;
  int n_err = 0;

  sfp_port_array #(.PORTS(PORTS), .DEBOUNCE_CYCLES(DB), .I2C_RST_CYCLES(RST)) dut (
    .clk(clk), .reset(reset), .los(los), .mod0_prsnt_n(prsnt_n), .tx_fault(fault),
    .tx_disable(tx_disable), .ratesel(ratesel), .i2c_reset(i2c_reset), .irq(irq),
    .mm_address(mm_address), .mm_read(mm_read), .mm_readdata(mm_readdata),
    .mm_write(mm_write), .mm_writedata(mm_writedata), .mm_response(mm_response)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: input index 0 present, 1 los, 2 fault.
  int m_s1[2][3], m_s2[2][3], m_deb[2][3], m_run[2][3];
  int m_ev[2], m_mask[2], m_auto[2], m_tx[2], m_rate[2], m_pulse[2], m_ins[2];
  int m_rdata, m_resp;

  function automatic int raw_in(int p, int i);
    if (i == 0) return prsnt_n[p] ? 0 : 1;
    if (i == 1) return int'(los[p]);
    return int'(fault[p]);
  endfunction

  function automatic int model_read(int p, int r);
    case (r)
      0: return m_deb[p][0] + 2 * m_deb[p][1] + 4 * m_deb[p][2] + 8 * m_tx[p]
                + 16 * m_rate[p] + ((m_pulse[p] > 0) ? 64 : 0);
      1: return m_ev[p];
      2: return m_mask[p];
      default: return m_auto[p];
    endcase
  endfunction

  task automatic model_step();
    int aport, areg, ok, wr, trig, frc;
    int newdeb[2][3];
    int evs[2];
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 3; i++) begin
          m_s1[p][i] = (i == 1); m_s2[p][i] = (i == 1); m_deb[p][i] = (i == 1); m_run[p][i] = 0;
        end
        m_ev[p] = 0; m_mask[p] = 0; m_auto[p] = 3; m_tx[p] = 1; m_rate[p] = 0;
        m_pulse[p] = 0; m_ins[p] = 0;
      end
      m_rdata = 0; m_resp = 0;
      return;
    end
    aport = int'(mm_address[5:2]);
    areg  = int'(mm_address[1:0]);
    ok    = (aport < PORTS);
    if (mm_read) begin
      m_resp  = ok ? 3'd0 : 3'd3;
      m_rdata = ok ? model_read(aport, areg) : 0;
    end else begin
      m_resp = 0;
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        newdeb[p][i] = m_deb[p][i];
        if (m_s2[p][i] != m_deb[p][i]) begin
          m_run[p][i]++;
          if (m_run[p][i] == DB) begin newdeb[p][i] = m_s2[p][i]; m_run[p][i] = 0; end
        end else m_run[p][i] = 0;
      end
      evs[p] = 0;
      if (newdeb[p][0] == 1 && m_deb[p][0] == 0) evs[p] += 1;
      if (newdeb[p][0] == 0 && m_deb[p][0] == 1) evs[p] += 2;
      if (newdeb[p][1] == 1 && m_deb[p][1] == 0) evs[p] += 4;
      if (newdeb[p][1] == 0 && m_deb[p][1] == 1) evs[p] += 8;
      if (newdeb[p][2] == 1 && m_deb[p][2] == 0) evs[p] += 16;
      wr   = mm_write && ok && (aport == p);
      trig = m_ins[p] || (wr && areg == 0 && mm_writedata[6]);
      if (trig) m_pulse[p] = RST;
      else if (m_pulse[p] > 0) m_pulse[p]--;
      m_ins[p] = evs[p] & 1;
      if (wr && areg == 1) m_ev[p] = m_ev[p] & ~int'(mm_writedata[4:0]);
      m_ev[p] = m_ev[p] | evs[p];
      frc = ((m_auto[p] & 1) && (evs[p] & 2)) || ((m_auto[p] & 2) && (evs[p] & 16));
      if (wr && areg == 0) begin m_tx[p] = int'(mm_writedata[3]); m_rate[p] = int'(mm_writedata[5:4]); end
      if (frc) m_tx[p] = 1;
      if (wr && areg == 2) m_mask[p] = int'(mm_writedata[4:0]);
      if (wr && areg == 3) m_auto[p] = int'(mm_writedata[1:0]);
      for (int i = 0; i < 3; i++) begin
        m_deb[p][i] = newdeb[p][i];
        m_s2[p][i]  = m_s1[p][i];
        m_s1[p][i]  = raw_in(p, i);
      end
    end
  endtask

  always @(posedge clk) model_step();

  // scoreboard: every output against the model on the falling edge
  always @(negedge clk) begin
    logic [1:0] e_tx, e_i2c;
    logic [3:0] e_rate;
    logic       e_irq;
    e_irq = 1'b0;
    for (int p = 0; p < 2; p++) begin
      e_tx[p]         = (m_tx[p] != 0);
      e_i2c[p]        = reset || (m_pulse[p] > 0);
      e_rate[2*p +: 2] = 2'(m_rate[p]);
      e_irq           = e_irq | ((m_ev[p] & m_mask[p]) != 0);
    end
    check("tx_disable", tx_disable, e_tx);
    check("ratesel", ratesel, e_rate);
    check("i2c_reset", i2c_reset, e_i2c);
    check("irq", irq, e_irq);
    check("response", mm_response, m_resp);
    check("readdata", mm_readdata, m_rdata);
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    mm_address = a; mm_writedata = d; mm_write = 1'b1;
    cyc(1);
    mm_write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a);
    mm_address = a; mm_read = 1'b1;
    cyc(1);
    mm_read = 1'b0;
  endtask

  initial begin
    los = 2'b11; prsnt_n = 2'b11; fault = 2'b00;
    mm_read = 0; mm_write = 0; mm_address = 0; mm_writedata = 0;
    cyc(3);
    check("rst_i2c", i2c_reset, 2'b11);
    check("rst_tx", tx_disable, 2'b11);
    check("rst_rate", ratesel, 4'h0);
    check("rst_irq", irq, 1'b0);
    reset = 1'b0;
    bus_read(6'h00);
    check("ctrl0_rst", mm_readdata, 8'h0A);

    // cage 1 insertion: debounced at edge 10, i2c pulse edges 11..26
    prsnt_n[1] = 1'b0;
    cyc(10);
    check("ins_i2c_pre", i2c_reset[1], 1'b0);
    bus_read(6'h05);
    check("ins_event", mm_readdata, 8'h01);
    check("ins_i2c_on", i2c_reset[1], 1'b1);
    repeat (15) begin cyc(1); check("ins_i2c_hold", i2c_reset[1], 1'b1); end
    cyc(1);
    check("ins_i2c_off", i2c_reset[1], 1'b0);
    bus_read(6'h04);
    check("ctrl1_present", mm_readdata, 8'h0B);

    // los glitch then real fall on cage 0
    los[0] = 1'b0; cyc(5); los[0] = 1'b1; cyc(15);
    bus_read(6'h01);
    check("glitch_event", mm_readdata, 8'h00);
    bus_write(6'h02, 8'h08);
    los[0] = 1'b0; cyc(12);
    check("irq_set", irq, 1'b1);
    bus_write(6'h01, 8'h08);
    check("irq_clr", irq, 1'b0);

    // host ctrl write, then auto disable on removal
    bus_write(6'h00, 8'h30);
    check("ctrl_tx", tx_disable[0], 1'b0);
    check("ctrl_rate", ratesel[1:0], 2'b11);
    prsnt_n[0] = 1'b0; cyc(12);
    prsnt_n[0] = 1'b1; cyc(9);
    check("rm_tx_pre", tx_disable[0], 1'b0);
    cyc(1);
    check("rm_tx_auto", tx_disable[0], 1'b1);
    bus_read(6'h01);
    check("rm_event", mm_readdata, 8'h03);
    bus_write(6'h03, 8'h02);
    prsnt_n[0] = 1'b0; cyc(12);
    bus_write(6'h00, 8'h30);
    prsnt_n[0] = 1'b1; cyc(14);
    check("rm_tx_noauto", tx_disable[0], 1'b0);

    // host i2c reset retrigger: continuous high cycles 1..26
    cyc(20);
    bus_write(6'h00, 8'h40);
    check("host_i2c_on", i2c_reset[0], 1'b1);
    repeat (9) begin cyc(1); check("host_i2c_a", i2c_reset[0], 1'b1); end
    bus_write(6'h00, 8'h40);
    check("host_i2c_re", i2c_reset[0], 1'b1);
    repeat (15) begin cyc(1); check("host_i2c_b", i2c_reset[0], 1'b1); end
    cyc(1);
    check("host_i2c_off", i2c_reset[0], 1'b0);

    // out-of-range port
    bus_read(6'h08);
    check("oor_resp", mm_response, 2'b11);
    check("oor_data", mm_readdata, 8'h00);
    bus_write(6'h08, 8'hFF);
    bus_write(6'h0A, 8'hFF);
    bus_write(6'h0B, 8'hFF);
    bus_read(6'h02);
    check("oor_mask0", mm_readdata, 8'h08);
    bus_read(6'h03);
    check("oor_auto0", mm_readdata, 8'h02);

    // random traffic, occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 11) == 0) los[p] = ~los[p];
        if ($urandom_range(0, 11) == 0) prsnt_n[p] = ~prsnt_n[p];
        if ($urandom_range(0, 15) == 0) fault[p] = ~fault[p];
      end
      mm_address   = 6'($urandom_range(0, 11));
      mm_writedata = 8'($urandom_range(0, 255));
      mm_read      = ($urandom_range(0, 3) == 0);
      mm_write     = ($urandom_range(0, 4) == 0);
      reset        = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    mm_read = 0; mm_write = 0; reset = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
